mod_n_down_counter_sync: RTL and testbench

- Synchronous mod-N down counter: the single-clock, counting-down counterpart to the team's asynchronous ripple mod-N up counters.
- Decrement requests arrive on decr_i as an unsynchronised level.
- decr_i is synchronised into clk_i, rising-edge detected, and each detected edge decrements count_o by one with wrap N-1 after 0.
- Provides load, zero flag and a borrow pulse so instances chain into multi-digit down timers.

---
 rtl/mod_n_counter_pkg.sv | 12 +
 rtl/sync_edge_detect.sv | 33 +++
 rtl/mod_n_down_counter_sync.sv | 73 +++++++
 tb/tb_mod_n_down_counter_sync.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mod_n_counter_pkg.sv
// Shared constants and helpers for the mod-N counter family.
package mod_n_counter_pkg;

   localparam int DEFAULT_N           = 5;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Width of a counter holding values 0..n-1.
   function automatic int width_f(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous level into clk_i and emits a one-cycle
// pulse for each rising edge seen at the end of the synchroniser chain.
module sync_edge_detect
   import mod_n_counter_pkg::*;
#(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
)(
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Synchroniser chain plus edge-history flop; reset drops any in-flight edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Rising-edge decode on the synchronised level.
   always_comb begin
      pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

endmodule

// File: rtl/mod_n_down_counter_sync.sv
// Synchronous mod-N down counter with load, zero flag and a registered
// borrow pulse on wrap 0 -> N-1 for chaining into multi-digit timers.
module mod_n_down_counter_sync
   import mod_n_counter_pkg::*;
#(
   parameter  int N           = DEFAULT_N,
   parameter  int SYNC_STAGES = DEFAULT_SYNC_STAGES,
   localparam int W           = width_f(N)
)(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         decr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] count_o,
   output logic         zero_o,
   output logic         borrow_o
);

   localparam logic [W-1:0] MAX_CNT = W'(N - 1);
   localparam logic [W-1:0] ONE     = W'(1);
   localparam logic [W:0]   N_EXT   = (W + 1)'(N);

   logic         dec_p;
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         borrow_q;
   logic         borrow_d;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (decr_i),
      .pulse_o (dec_p)
   );

   // Next count: load (saturated to N-1) beats decrement; a coincident edge is dropped.
   always_comb begin
      count_d  = count_q;
      borrow_d = 1'b0;
      if (load_i) begin
         count_d = ({1'b0, load_val_i} >= N_EXT) ? MAX_CNT : load_val_i;
      end else if (dec_p) begin
         if (count_q == '0) begin
            count_d  = MAX_CNT;
            borrow_d = 1'b1;
         end else begin
            count_d = count_q - ONE;
         end
      end
   end

   // Count and borrow registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q  <= '0;
         borrow_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         borrow_q <= borrow_d;
      end
   end

   // Outputs: registered count and borrow, zero decoded from the count register.
   always_comb begin
      count_o  = count_q;
      borrow_o = borrow_q;
      zero_o   = (count_q == '0);
   end

endmodule

// File: tb/tb_mod_n_down_counter_sync.sv
// Randomised and directed bench for mod_n_down_counter_sync, checked
// against an event-scheduling reference model; also a two-digit chain.
module tb_mod_n_down_counter_sync;

   localparam int N  = 5;
   localparam int SS = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1, decr = 1'b0, load = 1'b0;
   logic [2:0] lval = '0;
   logic [2:0] count;
   logic       zero, borrow;

   logic       rst_c = 1'b1, decr_c = 1'b0;
   logic [2:0] lo_count, up_count;
   logic       lo_zero, lo_borrow, up_zero, up_borrow;

   int n_checks = 0;
   int n_pass   = 0;
   int ecount   = 0;

   // Reference model state: index 0 = main DUT, 1 = lower digit, 2 = upper digit.
   int m_cnt  [3];
   bit m_brw  [3];
   bit m_ls   [3];
   int m_pend [3][$];

   always #5 clk = ~clk;

   mod_n_down_counter_sync #(.N(N), .SYNC_STAGES(SS)) dut (
      .clk_i(clk), .rst_i(rst), .decr_i(decr), .load_i(load), .load_val_i(lval),
      .count_o(count), .zero_o(zero), .borrow_o(borrow));

   mod_n_down_counter_sync #(.N(N), .SYNC_STAGES(SS)) u_lo (
      .clk_i(clk), .rst_i(rst_c), .decr_i(decr_c), .load_i(1'b0), .load_val_i(3'd0),
      .count_o(lo_count), .zero_o(lo_zero), .borrow_o(lo_borrow));

   mod_n_down_counter_sync #(.N(N), .SYNC_STAGES(SS)) u_up (
      .clk_i(clk), .rst_i(rst_c), .decr_i(lo_borrow), .load_i(1'b0), .load_val_i(3'd0),
      .count_o(up_count), .zero_o(up_zero), .borrow_o(up_borrow));

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s at edge %0d: got %0d expected %0d", tag, ecount, obs, exp);
   endtask

   // One clock edge of the reference model. A rising edge first sampled at
   // edge e is scheduled to change the count at edge e+SS; reset cancels it.
   task automatic model_edge(input int id, input bit r, input bit ld, input int lv, input bit d);
      bit fire;
      if (r) begin
         m_cnt[id] = 0;
         m_brw[id] = 0;
         m_ls[id]  = 0;
         m_pend[id].delete();
      end else begin
         fire = 0;
         if (m_pend[id].size() > 0 && m_pend[id][0] == ecount) begin
            fire = 1;
            void'(m_pend[id].pop_front());
         end
         m_brw[id] = 0;
         if (ld) m_cnt[id] = (lv >= N) ? N - 1 : lv;
         else if (fire) begin
            if (m_cnt[id] == 0) begin
               m_cnt[id] = N - 1;
               m_brw[id] = 1;
            end else m_cnt[id] = m_cnt[id] - 1;
         end
         if (d && !m_ls[id]) m_pend[id].push_back(ecount + SS);
         m_ls[id] = d;
      end
   endtask

   task automatic tick();
      bit ub;
      ub = m_brw[1];
      @(posedge clk);
      ecount++;
      model_edge(0, rst, load, int'(lval), decr);
      model_edge(1, rst_c, 1'b0, 0, decr_c);
      model_edge(2, rst_c, 1'b0, 0, ub);
      #1;
      chk("count",     int'(count),     m_cnt[0]);
      chk("zero",      int'(zero),      int'(m_cnt[0] == 0));
      chk("borrow",    int'(borrow),    int'(m_brw[0]));
      chk("lo_count",  int'(lo_count),  m_cnt[1]);
      chk("lo_borrow", int'(lo_borrow), int'(m_brw[1]));
      chk("up_count",  int'(up_count),  m_cnt[2]);
      chk("up_borrow", int'(up_borrow), int'(m_brw[2]));
      chk("up_zero",   int'(up_zero),   int'(m_cnt[2] == 0));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int hold, hold_c;
      int wraps;

      // Reset
      ticks(2);
      chk("rst_count", int'(count), 0);
      chk("rst_zero", int'(zero), 1);
      chk("rst_borrow", int'(borrow), 0);
      rst = 1'b0;
      rst_c = 1'b0;
      ticks(2);

      // Six clean pulses: 0 -> 4,3,2,1,0,4 with a borrow on each wrap
      wraps = 0;
      for (int p = 0; p < 6; p++) begin
         decr = 1'b1;
         for (int k = 0; k < 3; k++) begin tick(); if (borrow) wraps++; end
         decr = 1'b0;
         for (int k = 0; k < 3; k++) begin tick(); if (borrow) wraps++; end
      end
      chk("six_pulses_count", int'(count), 4);
      chk("six_pulses_wraps", wraps, 2);

      // Latency: load 3, then rising edge before E1 shows at E3
      load = 1'b1; lval = 3'd3; tick();
      load = 1'b0; ticks(2);
      decr = 1'b1;
      tick(); chk("lat_e1", int'(count), 3);
      tick(); chk("lat_e2", int'(count), 3);
      tick(); chk("lat_e3", int'(count), 2);
      decr = 1'b0; ticks(3);

      // Load and saturation
      load = 1'b1; lval = 3'd2; tick(); chk("load2", int'(count), 2);
      lval = 3'd7; tick(); chk("load7_sat", int'(count), 4);
      chk("load_borrow", int'(borrow), 0);
      load = 1'b0; ticks(2);

      // Load coincident with the decrement pulse drops the edge
      decr = 1'b1; ticks(2);
      load = 1'b1; lval = 3'd1; tick();
      load = 1'b0; ticks(4);
      chk("load_vs_dec", int'(count), 1);
      decr = 1'b0; ticks(3);

      // Reset mid-synchronisation with decr held high
      decr = 1'b1; tick();
      rst = 1'b1; tick();
      rst = 1'b0; chk("midrst_cnt", int'(count), 0);
      ticks(2); chk("midrst_hold", int'(count), 0);
      tick(); chk("midrst_dec", int'(count), 4);
      chk("midrst_borrow", int'(borrow), 1);
      ticks(5); chk("midrst_after", int'(count), 4);
      chk("midrst_borrow_off", int'(borrow), 0);
      decr = 1'b0; ticks(3);

      // Chain: five lower decrements -> lower 0, upper 4
      rst_c = 1'b1; tick(); rst_c = 1'b0; tick();
      for (int p = 0; p < 5; p++) begin
         decr_c = 1'b1; ticks(3);
         decr_c = 1'b0; ticks(3);
      end
      ticks(4);
      chk("chain_lo", int'(lo_count), 0);
      chk("chain_up", int'(up_count), 4);

      // Randomised phase
      hold = 0;
      hold_c = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin decr = ~decr; hold = $urandom_range(1, 4); end
         hold--;
         if (hold_c == 0) begin decr_c = ~decr_c; hold_c = $urandom_range(1, 4); end
         hold_c--;
         load  = ($urandom_range(0, 29) == 0);
         lval  = 3'($urandom_range(0, 7));
         rst   = ($urandom_range(0, 99) == 0);
         rst_c = ($urandom_range(0, 149) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
